lcg_stream_checker: RTL and testbench

//  Receive-side counterpart of the bench LCG stimulus driver. Regenerates the
//  LCG word sequence from a programmed seed and checks each word arriving on a

---
 rtl/lcg_pkg.sv | 23 ++
 rtl/lcg_word_gen.sv | 66 ++++++
 rtl/lcg_stream_checker.sv | 115 +++++++++++
 tb/tb_lcg_stream_checker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcg_pkg.sv
// Shared LCG constants, step function and checker FSM encoding.
// Used by both the hardware checker and bench-side stimulus drivers.
package lcg_pkg;

  localparam logic [31:0] DEF_LCG_MUL = 32'h41C64E6D;
  localparam logic [31:0] DEF_LCG_INC = 32'h00003039;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } checker_state_e;

  function automatic logic [31:0] lcg_next(
    input logic [31:0] s,
    input logic [31:0] mul = DEF_LCG_MUL,
    input logic [31:0] inc = DEF_LCG_INC
  );
    return s * mul + inc;
  endfunction

endpackage

// File: rtl/lcg_word_gen.sv
// LCG word builder: one LCG step per enabled cycle, each step's result lands
// in the next 32-bit chunk of the output word; the generator state carries across words.
module lcg_word_gen
  import lcg_pkg::*;
#(
  parameter int          WIDTH   = 136,
  parameter logic [31:0] LCG_MUL = DEF_LCG_MUL,
  parameter logic [31:0] LCG_INC = DEF_LCG_INC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [31:0]      i_seed,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_word,
  output logic             o_last_chunk,
  output logic             o_word_ready
);

  localparam int NCHUNK = (WIDTH + 31) / 32;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  logic [31:0]      r_lcg;
  logic [IDX_W-1:0] r_idx;
  logic             r_word_ready;
  logic [31:0]      w_lcg_next;

  assign w_lcg_next   = lcg_next(r_lcg, LCG_MUL, LCG_INC);
  assign o_last_chunk = (r_idx == IDX_W'(NCHUNK - 1));
  assign o_word_ready = r_word_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lcg        <= '0;
      r_idx        <= '0;
      r_word_ready <= 1'b0;
    end else if (i_load) begin
      r_lcg        <= i_seed;
      r_idx        <= '0;
      r_word_ready <= 1'b0;
    end else if (i_step) begin
      r_lcg        <= w_lcg_next;
      r_idx        <= o_last_chunk ? '0 : r_idx + 1'b1;
      r_word_ready <= o_last_chunk;
    end
  end

  // The top chunk is only as wide as the bits left over above 32*(NCHUNK-1).
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      localparam int CW = (gi == NCHUNK - 1) ? WIDTH - 32 * (NCHUNK - 1) : 32;
      logic [CW-1:0] r_chunk;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_chunk <= '0;
        end else if (i_step && (r_idx == IDX_W'(gi))) begin
          r_chunk <= w_lcg_next[CW-1:0];
        end
      end

      assign o_word[32*gi +: CW] = r_chunk;
    end
  endgenerate

endmodule

// File: rtl/lcg_stream_checker.sv
// Checks a valid/ready word stream against a regenerated LCG sequence and
// reports mismatch count, first failing index and pass/fail per run.
module lcg_stream_checker
  import lcg_pkg::*;
#(
  parameter int          WIDTH   = 136,
  parameter logic [31:0] LCG_MUL = DEF_LCG_MUL,
  parameter logic [31:0] LCG_INC = DEF_LCG_INC,
  parameter int          CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] num_words,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             first_mismatch_vld,
  output logic [CNT_W-1:0] first_mismatch_idx
);

  checker_state_e   r_state;
  logic [CNT_W-1:0] r_num_words;
  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] r_mis_cnt;
  logic [CNT_W-1:0] r_first_idx;
  logic             r_first_vld;

  logic             w_load;
  logic             w_step;
  logic             w_hs;
  logic             w_mismatch;
  logic             w_last_chunk;
  logic             w_word_ready;
  logic [WIDTH-1:0] w_exp_word;

  assign w_load     = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_step     = (r_state == GEN);
  assign in_ready   = (r_state == WAIT) && w_word_ready;
  assign w_hs       = in_valid && in_ready;
  assign w_mismatch = w_hs && (in_data != w_exp_word);

  lcg_word_gen #(
    .WIDTH   (WIDTH),
    .LCG_MUL (LCG_MUL),
    .LCG_INC (LCG_INC)
  ) u_word_gen (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_seed       (seed),
    .i_step       (w_step),
    .o_word       (w_exp_word),
    .o_last_chunk (w_last_chunk),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_num_words <= '0;
      r_word_cnt  <= '0;
      r_mis_cnt   <= '0;
      r_first_idx <= '0;
      r_first_vld <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_num_words <= num_words;
            r_word_cnt  <= '0;
            r_mis_cnt   <= '0;
            r_first_idx <= '0;
            r_first_vld <= 1'b0;
            r_state     <= (num_words == '0) ? DONE : GEN;
          end
        end
        GEN: begin
          if (w_last_chunk) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (w_hs) begin
            r_word_cnt <= r_word_cnt + 1'b1;
            if (w_mismatch) begin
              if (r_mis_cnt != '1) begin
                r_mis_cnt <= r_mis_cnt + 1'b1;
              end
              if (!r_first_vld) begin
                r_first_vld <= 1'b1;
                r_first_idx <= r_word_cnt;
              end
            end
            r_state <= ((r_word_cnt + 1'b1) == r_num_words) ? DONE : GEN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy               = (r_state == GEN) || (r_state == WAIT);
  assign done               = (r_state == DONE);
  assign pass               = done && (r_mis_cnt == '0);
  assign mismatch_count     = r_mis_cnt;
  assign first_mismatch_vld = r_first_vld;
  assign first_mismatch_idx = r_first_idx;

endmodule

// File: tb/tb_lcg_stream_checker.sv
// Directed bench for lcg_stream_checker: streams an independently modelled
// LCG word sequence, with optional bit flips, restarts and mid-run reset.
module tb_lcg_stream_checker;

  localparam int WIDTH  = 136;
  localparam int CNT_W  = 32;
  localparam int NCHUNK = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      seed;
  logic [CNT_W-1:0] num_words;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] mismatch_count;
  logic             first_mismatch_vld;
  logic [CNT_W-1:0] first_mismatch_idx;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_s;

  always #5 clk = ~clk;

  lcg_stream_checker #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .seed               (seed),
    .num_words          (num_words),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_ready           (in_ready),
    .busy               (busy),
    .done               (done),
    .pass               (pass),
    .mismatch_count     (mismatch_count),
    .first_mismatch_vld (first_mismatch_vld),
    .first_mismatch_idx (first_mismatch_idx)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_next_word();
    logic [32*NCHUNK-1:0] full = '0;
    for (int j = 0; j < NCHUNK; j++) begin
      m_s = m_s * 32'h41C64E6D + 32'h00003039;
      full[32*j +: 32] = m_s;
    end
    return full[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] flip(input logic [WIDTH-1:0] w, input int idx,
                                            input int fw0, input int fb0, input int fw1, input int fb1);
    logic [WIDTH-1:0] r = w;
    if (idx == fw0) r[fb0] = ~r[fb0];
    if (idx == fw1) r[fb1] = ~r[fb1];
    return r;
  endfunction

  // Holds in_valid high and feeds max_hs words; start_at >= 0 pulses a stray start mid-run.
  task automatic run_stream(input logic [31:0] sd, input int n, input int max_hs,
                            input int fw0, input int fb0, input int fw1, input int fb1,
                            input int start_at, output int cycles, output int ready_cycles);
    int   idx = 0;
    int   cyc = 0;
    int   rdy = 0;
    logic hs;
    m_s       = sd;
    seed      = sd;
    num_words = CNT_W'(n);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (n != 0) begin
      check("start_clears_done", done, 1'b0);
      check("start_clears_mism", mismatch_count, 0);
      check("start_clears_fvld", first_mismatch_vld, 1'b0);
      check("start_sets_busy", busy, 1'b1);
    end
    in_data  = flip(model_next_word(), idx, fw0, fb0, fw1, fb1);
    in_valid = 1'b1;
    while (idx < max_hs && cyc < 2000) begin
      hs = in_ready;
      if (hs) rdy++;
      if (cyc == start_at) begin
        start     = 1'b1;
        seed      = 32'hFFFFFFFF;
        num_words = 2;
      end
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (hs) begin
        $display("[TB] seed %08h word %0d accepted", sd, idx);
        idx++;
        in_data = flip(model_next_word(), idx, fw0, fb0, fw1, fb1);
      end
    end
    in_valid = 1'b0;
    if (idx < max_hs) check("handshake_timeout", idx, max_hs);
    cycles       = cyc;
    ready_cycles = rdy;
  endtask

  initial begin
    int               cyc;
    int               rdy;
    logic [WIDTH-1:0] w;
    rst       = 1'b1;
    start     = 1'b0;
    seed      = '0;
    num_words = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_mism", mismatch_count, 0);
    check("rst_fvld", first_mismatch_vld, 1'b0);
    check("rst_fidx", first_mismatch_idx, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    m_s = 32'd0;
    w   = model_next_word();
    check("model_w0_c0", w[31:0], 32'h00003039);
    check("model_w0_c1", w[63:32], 32'hD3DC167E);

    // Clean 100-word run from seed 0.
    run_stream(32'd0, 100, 100, -1, 0, -1, 0, -1, cyc, rdy);
    check("clean_done", done, 1'b1);
    check("clean_pass", pass, 1'b1);
    check("clean_mism", mismatch_count, 0);
    check("clean_fvld", first_mismatch_vld, 1'b0);
    check("clean_busy", busy, 1'b0);

    // Restart from DONE with two corrupted words.
    run_stream(32'd0, 100, 100, 7, 135, 20, 0, -1, cyc, rdy);
    check("flip_done", done, 1'b1);
    check("flip_pass", pass, 1'b0);
    check("flip_mism", mismatch_count, 2);
    check("flip_fvld", first_mismatch_vld, 1'b1);
    check("flip_fidx", first_mismatch_idx, 7);

    // Throughput with in_valid held high.
    run_stream(32'h12345678, 10, 10, -1, 0, -1, 0, -1, cyc, rdy);
    check("tput_cycles", cyc, 10 * (NCHUNK + 1));
    check("tput_ready_cycles", rdy, 10);
    check("tput_done", done, 1'b1);
    check("tput_pass", pass, 1'b1);
    check("tput_in_ready_after", in_ready, 1'b0);

    // Zero-length run.
    in_valid  = 1'b1;
    in_data   = '0;
    seed      = 32'd0;
    num_words = '0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_done", done, 1'b1);
    check("zero_pass", pass, 1'b1);
    check("zero_in_ready", in_ready, 1'b0);
    check("zero_busy", busy, 1'b0);
    @(posedge clk); #1;
    check("zero_done_held", done, 1'b1);
    check("zero_mism", mismatch_count, 0);
    in_valid = 1'b0;

    // Reset during word 3 of 10, after a mismatch on word 1.
    run_stream(32'hCAFEBABE, 10, 3, 1, 5, -1, 0, -1, cyc, rdy);
    check("mid_mism", mismatch_count, 1);
    check("mid_fvld", first_mismatch_vld, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_mism", mismatch_count, 0);
    check("midrst_fvld", first_mismatch_vld, 1'b0);
    check("midrst_fidx", first_mismatch_idx, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_stream(32'd0, 1, 1, -1, 0, -1, 0, -1, cyc, rdy);
    check("replay_done", done, 1'b1);
    check("replay_pass", pass, 1'b1);

    // Stray start while busy must not restart or reseed the run.
    run_stream(32'd0, 5, 5, -1, 0, -1, 0, 2, cyc, rdy);
    check("busystart_done", done, 1'b1);
    check("busystart_pass", pass, 1'b1);
    check("busystart_cycles", cyc, 5 * (NCHUNK + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
